rv32i_fetch_unit: RTL and testbench

Instruction-fetch stage for the RV32I core. It owns the program counter and issues word reads on the instruction-memory port. It packages each returned instruction with its PC, PC+4 and next-PC prediction into a `fetch_ex_pipeline_reg_t` consumed directly by the execute stage. It handles execute back-pressure through a one-entry skid buffer and redirects from execute, including a redirect that arrives while a memory read is still outstanding.

---
 rtl/rv32i_fetch_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_rv32i_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_fetch_unit
// Purpose  : Instruction-fetch stage of the RV32I core. Owns the program
//            counter and issues word reads on the instruction-memory port.
//            Each returned word is packed with its PC, PC+4 and a next-PC
//            prediction into the fetch->execute pipeline register. Execute
//            back-pressure is absorbed by a one-entry skid buffer. Redirects
//            from execute flush the stage. A redirect that arrives while a
//            read is still outstanding parks the stage in DISCARD until that
//            read completes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC      : first PC fetched after reset
// Ports
//   CLK           : clock, rising edge
//   nRST          : asynchronous active-low reset
//   imem_ren      : instruction read request
//   imem_addr     : word address of the request (bits [1:0] always 0)
//   imem_busy     : memory has not completed the current request
//   imem_rdata    : instruction word, valid when imem_ren && !imem_busy
//   stall         : execute cannot take a new fetch_ex_reg this cycle
//   redirect      : execute requests a flush and refetch
//   redirect_pc   : refetch target when redirect = 1
//   fetch_ex_reg  : {token, pc, pc4, instr, prediction}, token = valid
// Build option
//   BTFN_PREDICT_EN : when defined, a static backward-taken /
//                     forward-not-taken predictor decodes imem_rdata.
//                     When undefined the prediction is always PC+4.
// ============================================================================
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic         CLK,
    input  logic         nRST,
    output logic         imem_ren,
    output logic [31:0]  imem_addr,
    input  logic         imem_busy,
    input  logic [31:0]  imem_rdata,
    input  logic         stall,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic [128:0] fetch_ex_reg
);

    // ------------------------------------------------------------------------
    // State encoding
    //   ST_FETCH   : requesting the word at pc
    //   ST_FULL    : skid buffer holds an instruction, no request issued
    //   ST_DISCARD : a read is in flight that was made stale by a redirect
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_FULL    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [31:0]   r_pc;
    logic [31:0]   r_hold_addr;     // address of the read being discarded
    logic [127:0]  r_skid;          // {pc, pc4, instr, prediction}
    logic [128:0]  r_out;

    logic          w_ren;
    logic [31:0]   w_addr;
    logic          w_complete;
    logic          w_in_flight;
    logic          w_fetch_done;    // completion whose data is kept
    logic          w_accept;
    logic          w_skid_valid;
    logic [31:0]   w_pc4;
    logic [31:0]   w_pred;
    logic [128:0]  w_entry;

    // The skid buffer is valid exactly while the FSM sits in ST_FULL, so its
    // valid flag is derived from the state rather than stored separately.
    assign w_skid_valid = (r_state == ST_FULL);

    // Execute takes a new value when it is not stalling or when the current
    // register holds nothing it still needs.
    assign w_accept = ~stall | ~r_out[128];

    assign w_pc4   = r_pc + 32'd4;
    assign w_entry = {1'b1, r_pc, w_pc4, imem_rdata, w_pred};

    // ------------------------------------------------------------------------
    // Next-PC prediction
    // ------------------------------------------------------------------------
`ifdef BTFN_PREDICT_EN
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    logic [31:0] w_imm_j;
    logic [31:0] w_imm_b;

    always_comb begin
        w_imm_j = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                   imem_rdata[30:21], 1'b0};
        w_imm_b = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                   imem_rdata[11:8], 1'b0};
        w_pred  = w_pc4;
        if (imem_rdata[6:0] == c_OPC_JAL) begin
            w_pred = r_pc + w_imm_j;
        end else if ((imem_rdata[6:0] == c_OPC_BRANCH) && imem_rdata[31]) begin
            // Negative branch offset: assume a loop back-edge is taken.
            w_pred = r_pc + w_imm_b;
        end
    end
`else
    assign w_pred = w_pc4;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: memory-port outputs and next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_ren        = 1'b0;
        w_addr       = {r_pc[31:2], 2'b00};
        w_complete   = 1'b0;
        w_in_flight  = 1'b0;
        w_fetch_done = 1'b0;
        w_state_next = r_state;

        case (r_state)
            ST_FETCH: begin
                w_ren = 1'b1;
            end
            ST_DISCARD: begin
                // Keep presenting the stale address until memory finishes it.
                w_ren  = 1'b1;
                w_addr = r_hold_addr;
            end
            default: begin
                w_ren = 1'b0;
            end
        endcase

        // No request may be visible while reset is held, even though the
        // reset state is ST_FETCH.
        w_ren        = w_ren & nRST;
        w_complete   = w_ren & ~imem_busy;
        w_in_flight  = w_ren & imem_busy;
        w_fetch_done = w_complete & (r_state == ST_FETCH);

        if (redirect) begin
            // An outstanding read must still be allowed to finish before the
            // new target can be requested.
            w_state_next = w_in_flight ? ST_DISCARD : ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_complete && !w_accept) begin
                        w_state_next = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_accept) begin
                        w_state_next = ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (w_complete) begin
                        w_state_next = ST_FETCH;
                    end
                end
                default: begin
                    w_state_next = ST_FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: PC, discard address, skid buffer and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pc        <= RESET_PC;
            r_hold_addr <= RESET_PC;
            r_skid      <= '0;
            r_out       <= '0;
        end else if (redirect) begin
            // Redirect wins over stall and over a same-cycle completion; the
            // completion's data is simply not captured.
            r_out[128] <= 1'b0;
            r_pc       <= {redirect_pc[31:2], 2'b00};
            if (w_in_flight) begin
                r_hold_addr <= w_addr;
            end
        end else begin
            if (w_fetch_done) begin
                r_pc <= w_pred;
            end

            if (w_accept) begin
                // The skid buffer is older than any new completion; in
                // practice both never coincide because ST_FULL issues no read.
                if (w_skid_valid) begin
                    r_out <= {1'b1, r_skid};
                end else if (w_fetch_done) begin
                    r_out <= w_entry;
                end else begin
                    r_out[128] <= 1'b0;
                end
            end else if (w_fetch_done) begin
                r_skid <= w_entry[127:0];
            end
        end
    end

    assign imem_ren     = w_ren;
    assign imem_addr    = w_addr;
    assign fetch_ex_reg = r_out;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_fetch_unit
// Purpose  : Randomised scoreboard bench for rv32i_fetch_unit. A program-order
//            model walks the instruction memory from the reset PC or from
//            each redirect target and queues the entries execute should see;
//            a monitor pops one entry for every value execute accepts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_fetch_unit;

    localparam logic [31:0] RST_PC   = 32'h0000_0200;
    localparam int          N_CYCLES = 4000;

    logic         CLK         = 1'b0;
    logic         nRST        = 1'b0;
    logic         imem_ren;
    logic [31:0]  imem_addr;
    logic         imem_busy   = 1'b0;
    logic [31:0]  imem_rdata;
    logic         stall       = 1'b0;
    logic         redirect    = 1'b0;
    logic [31:0]  redirect_pc = 32'h0;
    logic [128:0] fetch_ex_reg;

    logic [31:0]  mem [256];
    logic [128:0] exp_q [$];
    logic [31:0]  gen_pc;

    int n_tests    = 0;
    int n_fail     = 0;
    int n_consumed = 0;
    bit run_mon    = 1'b0;

    // monitor bookkeeping
    bit           hold_chk  = 1'b0;
    bit           full_chk  = 1'b0;
    bit           stab_chk  = 1'b0;
    bit           tgt_chk   = 1'b0;
    bit           disc_pend = 1'b0;
    logic [128:0] hold_val  = '0;
    logic [31:0]  stab_addr = '0;
    logic [31:0]  tgt_pc    = '0;
    int           idle      = 0;

    always #5 CLK = ~CLK;

    rv32i_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .imem_ren     (imem_ren),
        .imem_addr    (imem_addr),
        .imem_busy    (imem_busy),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .fetch_ex_reg (fetch_ex_reg)
    );

    // 1 KiB memory image, aliased over the whole address space.
    assign imem_rdata = mem[imem_addr[9:2]];

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] model_pred(input logic [31:0] pc);
        logic [31:0] nxt;
`ifdef BTFN_PREDICT_EN
        logic [31:0] ins;
`endif
        nxt = pc + 32'd4;
`ifdef BTFN_PREDICT_EN
        ins = mem[pc[9:2]];
        if (ins[6:0] == 7'b1101111)
            nxt = pc + {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        else if (ins[6:0] == 7'b1100011 && ins[31])
            nxt = pc + {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
`endif
        return nxt;
    endfunction

    function automatic logic [128:0] exp_entry(input logic [31:0] pc);
        return {1'b1, pc, pc + 32'd4, mem[pc[9:2]], model_pred(pc)};
    endfunction

    task automatic refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(exp_entry(gen_pc));
            gen_pc = model_pred(gen_pc);
        end
    endtask

    task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2;
        nRST      = 1'b0;
        run_mon   = 1'b0;
        stall     = 1'b0;
        redirect  = 1'b0;
        imem_busy = 1'b0;
        #1;
        chk("rst_ren",  imem_ren,     1'b0);
        chk("rst_out",  fetch_ex_reg, '0);
        chk("rst_addr", imem_addr,    RST_PC);
        exp_q.delete();
        gen_pc = RST_PC;
        refill();
        repeat (2) @(negedge CLK);
        #1 nRST = 1'b1;
        #1 chk("first_req", {imem_ren, imem_addr}, {1'b1, RST_PC});
        run_mon = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int busy_pct;
        int stall_pct;
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? 32'h0000_0013 : $urandom;
        do_reset();
        for (int c = 0; c < N_CYCLES && n_fail < 20; c++) begin
            @(posedge CLK);
            #1;
            if (c == N_CYCLES / 2) begin
                do_reset();
                continue;
            end
            busy_pct  = ((c / 250) % 3) * 35;
            stall_pct = ((c / 170) % 3) * 25;
            imem_busy = ($urandom_range(0, 99) < busy_pct);
            stall     = ($urandom_range(0, 99) < stall_pct);
            redirect  = ($urandom_range(0, 99) < 7);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'h0000_0403;
                1:       redirect_pc = 32'hFFFF_FFFC;
                default: redirect_pc = {22'h0, 8'($urandom), 2'($urandom)};
            endcase
            if (redirect) begin
                exp_q.delete();
                gen_pc = align(redirect_pc);
            end
            refill();
        end
        @(posedge CLK);
        #1;
        stall     = 1'b0;
        redirect  = 1'b0;
        imem_busy = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("throughput", (n_consumed > 200), 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ------------------------------------------------------------------------
    // Monitor: samples mid-cycle, inputs are stable from posedge+1
    // ------------------------------------------------------------------------
    always @(negedge CLK) begin
        if (!run_mon) begin
            hold_chk  = 1'b0;
            full_chk  = 1'b0;
            stab_chk  = 1'b0;
            tgt_chk   = 1'b0;
            disc_pend = 1'b0;
            idle      = 0;
        end else begin
            if (hold_chk) chk("hold_on_stall", fetch_ex_reg, hold_val);
            if (full_chk) chk("skid_full_no_req", imem_ren, 1'b0);
            if (stab_chk) chk("req_stable", {imem_ren, imem_addr}, {1'b1, stab_addr});
            if (tgt_chk)  chk("redirect_req", {imem_ren, imem_addr}, {1'b1, tgt_pc});
            if (imem_ren) chk("addr_aligned", imem_addr[1:0], 2'b00);

            hold_chk = fetch_ex_reg[128] && stall && !redirect;
            hold_val = fetch_ex_reg;
            full_chk = fetch_ex_reg[128] && stall && !redirect && !disc_pend
                       && imem_ren && !imem_busy;
            stab_chk  = imem_ren && imem_busy;
            stab_addr = imem_addr;

            tgt_chk = 1'b0;
            if (redirect) begin
                tgt_pc = align(redirect_pc);
                if (imem_ren && imem_busy) begin
                    disc_pend = 1'b1;
                end else begin
                    disc_pend = 1'b0;
                    tgt_chk   = 1'b1;
                end
            end else if (disc_pend && imem_ren && !imem_busy) begin
                disc_pend = 1'b0;
                tgt_chk   = 1'b1;
            end

            if (fetch_ex_reg[128] && !stall && !redirect) begin
                idle = 0;
                n_consumed++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got %h, expected no output", fetch_ex_reg);
                end else begin
                    chk("scoreboard", fetch_ex_reg, exp_q.pop_front());
                end
            end else begin
                idle++;
                if (idle > 400) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL timeout: got no accepted output for %0d cycles, expected progress", idle);
                    idle = 0;
                end
            end
        end
    end

endmodule
`default_nettype wire
